// File: rtl/dw_pkg.sv
// Shared types, default parameter constants and the saturation helper
// for the delta_w stream generator.
package dw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } dw_state_t;

  localparam int DEF_XW       = 8;
  localparam int DEF_LW       = 1;
  localparam int DEF_DW       = 8;
  localparam int DEF_DEPTH    = 64;
  localparam int DEF_LR_SHIFT = 0;

  // Products are widened to this before clamping so one function serves any DW.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                     input int dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dw_sample_fifo.sv
// Circular sample buffer: oldest-first reads, pointers wrap modulo DEPTH.
module dw_sample_fifo
  import dw_pkg::*;
#(
  parameter int XW    = DEF_XW,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic signed [XW-1:0] din,
  output logic signed [XW-1:0] dout,
  output logic [AW:0]          count,
  output logic                 full,
  output logic                 empty
);

  logic signed [XW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; count gates every read.
  always_ff @(posedge Clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/delta_w_stream.sv
// Buffers feature samples, then streams error*x >>> LR_SHIFT (saturated)
// per sample over a valid/ready handshake when an update pass is started.
module delta_w_stream
  import dw_pkg::*;
#(
  parameter int XW       = DEF_XW,
  parameter int LW       = DEF_LW,
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LR_SHIFT = DEF_LR_SHIFT,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int PW      = LW + XW + 1
) (
  input  logic                 Clk,
  input  logic                 RST,
  input  logic signed [XW-1:0] in,
  input  logic                 Record_X,
  input  logic [LW-1:0]        label,
  input  logic [LW-1:0]        Hw,
  input  logic                 Up_W,
  input  logic                 Clear,
  output logic signed [DW-1:0] delta_w,
  output logic                 dw_valid,
  input  logic                 dw_ready,
  output logic                 dw_last,
  output logic                 done,
  output logic                 busy,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty,
  output logic                 drop
);

  dw_state_t state;
  logic signed [LW:0]       err;
  logic signed [XW-1:0]     x_head;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     prod_sh;
  logic signed [SAT_W-1:0]  prod_wide;
  logic signed [SAT_W-1:0]  sat_val;
  logic signed [DW-1:0]     delta_next;
  logic                     last_next;
  logic                     accept;
  logic                     push;
  logic                     pop;

  assign accept = dw_valid && dw_ready;
  assign push   = !Clear && (state == ST_IDLE) && Record_X && !full;
  assign pop    = !Clear && ((state == ST_LOAD) ||
                             ((state == ST_STREAM) && accept && !dw_last));
  assign busy   = (state != ST_IDLE);

  dw_sample_fifo #(
    .XW    (XW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .RST   (RST),
    .clear (Clear),
    .push  (push),
    .pop   (pop),
    .din   (in),
    .dout  (x_head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Full-width product, floor shift, then clamp to DW.
  assign prod       = PW'(err) * PW'(x_head);
  assign prod_sh    = prod >>> LR_SHIFT;
  assign prod_wide  = SAT_W'(prod_sh);
  assign sat_val    = sat_dw(prod_wide, DW);
  assign delta_next = DW'(sat_val);
  // count is sampled before the pop, so 1 means the head is the final sample.
  assign last_next  = (count == CW'(1));

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      err      <= '0;
      delta_w  <= '0;
      dw_valid <= 1'b0;
      dw_last  <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (Clear) begin
        state    <= ST_IDLE;
        dw_valid <= 1'b0;
        dw_last  <= 1'b0;
        drop     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (Record_X && full) drop <= 1'b1;
            if (Up_W) begin
              if (!empty) begin
                err   <= $signed({1'b0, label}) - $signed({1'b0, Hw});
                state <= ST_LOAD;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            if (Record_X) drop <= 1'b1;
            delta_w  <= delta_next;
            dw_valid <= 1'b1;
            dw_last  <= last_next;
            state    <= ST_STREAM;
          end
          ST_STREAM: begin
            if (Record_X) drop <= 1'b1;
            if (accept) begin
              if (dw_last) begin
                dw_valid <= 1'b0;
                dw_last  <= 1'b0;
                done     <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                delta_w <= delta_next;
                dw_last <= last_next;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delta_w_stream.sv
// Directed bench: two instances (LR_SHIFT 0 and 2, DEPTH 4) share stimulus.
module tb_delta_w_stream;

  logic              Clk = 1'b0;
  logic              RST;
  logic signed [7:0] x_in;
  logic              Record_X;
  logic [0:0]        label;
  logic [0:0]        Hw;
  logic              Up_W;
  logic              Clear;
  logic              dw_ready;

  logic signed [7:0] d_a, d_b;
  logic              v_a, v_b, l_a, l_b, done_a, done_b, busy_a, busy_b;
  logic              full_a, full_b, empty_a, empty_b, drop_a, drop_b;
  logic [2:0]        cnt_a, cnt_b;

  int n_checks = 0;
  int n_errors = 0;
  int exp_a [8];
  int exp_b [8];

  always #5 Clk = ~Clk;

  delta_w_stream #(.XW(8), .LW(1), .DW(8), .DEPTH(4), .LR_SHIFT(0)) u_dut_a (
    .Clk(Clk), .RST(RST), .in(x_in), .Record_X(Record_X), .label(label), .Hw(Hw),
    .Up_W(Up_W), .Clear(Clear), .delta_w(d_a), .dw_valid(v_a), .dw_ready(dw_ready),
    .dw_last(l_a), .done(done_a), .busy(busy_a), .count(cnt_a), .full(full_a),
    .empty(empty_a), .drop(drop_a)
  );

  delta_w_stream #(.XW(8), .LW(1), .DW(8), .DEPTH(4), .LR_SHIFT(2)) u_dut_b (
    .Clk(Clk), .RST(RST), .in(x_in), .Record_X(Record_X), .label(label), .Hw(Hw),
    .Up_W(Up_W), .Clear(Clear), .delta_w(d_b), .dw_valid(v_b), .dw_ready(dw_ready),
    .dw_last(l_b), .done(done_b), .busy(busy_b), .count(cnt_b), .full(full_b),
    .empty(empty_b), .drop(drop_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic record(input int v);
    x_in = 8'(v);
    Record_X = 1'b1;
    tick();
    Record_X = 1'b0;
  endtask

  // Runs one pass expecting n deltas; optionally stalls dw_ready on item stall_at.
  task automatic run_pass(input string tag, input int n, input int stall_at, input int stall_len);
    int k;
    int cyc;
    int early_done;
    bit stalled;
    k = 0; cyc = 0; early_done = 0; stalled = 0;
    Up_W = 1'b1;
    tick();
    Up_W = 1'b0;
    dw_ready = 1'b1;
    label = ~label;
    Hw = ~Hw;
    while (k < n && cyc < 40) begin
      tick();
      cyc++;
      if (done_a) early_done++;
      if (k > 0) chk({tag, "_nobubble"}, int'(v_a), 1);
      if (v_a) begin
        if (k == stall_at && !stalled) begin
          dw_ready = 1'b0;
          for (int s = 0; s < stall_len; s++) begin
            tick();
            chk({tag, "_hold_a"}, int'(d_a), exp_a[k]);
            chk({tag, "_hold_v"}, int'(v_a), 1);
          end
          dw_ready = 1'b1;
          stalled = 1;
        end
        chk({tag, "_d_a"}, int'(d_a), exp_a[k]);
        chk({tag, "_d_b"}, int'(d_b), exp_b[k]);
        chk({tag, "_last"}, int'(l_a), (k == n - 1) ? 1 : 0);
        k++;
      end
    end
    chk({tag, "_count_out"}, k, n);
    chk({tag, "_early_done"}, early_done, 0);
    tick();
    chk({tag, "_done"}, int'(done_a), 1);
    chk({tag, "_valid_off"}, int'(v_a), 0);
    chk({tag, "_empty"}, int'(empty_a), 1);
    chk({tag, "_idle"}, int'(busy_a), 0);
    tick();
    chk({tag, "_done_pulse"}, int'(done_a), 0);
  endtask

  initial begin
    RST = 1'b1; x_in = '0; Record_X = 0; label = 0; Hw = 0;
    Up_W = 0; Clear = 0; dw_ready = 0;
    tick(); tick();
    RST = 1'b0;
    tick();

    chk("rst_count", int'(cnt_a), 0);
    chk("rst_empty", int'(empty_a), 1);
    chk("rst_full", int'(full_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_valid", int'(v_a), 0);
    chk("rst_delta", int'(d_a), 0);
    chk("rst_drop", int'(drop_a), 0);
    chk("rst_done", int'(done_a), 0);

    // Up_W with nothing buffered
    Up_W = 1'b1;
    tick();
    Up_W = 1'b0;
    chk("empty_upw_done", int'(done_a), 1);
    chk("empty_upw_valid", int'(v_a), 0);
    chk("empty_upw_busy", int'(busy_a), 0);
    tick();
    chk("empty_upw_done_off", int'(done_a), 0);
    chk("empty_upw_valid2", int'(v_a), 0);

    // Basic pass, error +1
    label = 1; Hw = 0;
    record(5); record(-3); record(127);
    chk("basic_count", int'(cnt_a), 3);
    exp_a[0] = 5;  exp_a[1] = -3; exp_a[2] = 127;
    exp_b[0] = 1;  exp_b[1] = -1; exp_b[2] = 31;
    run_pass("basic", 3, -1, 0);

    // Saturation, error -1
    label = 0; Hw = 1;
    record(-128);
    exp_a[0] = 127; exp_b[0] = 32;
    run_pass("sat", 1, -1, 0);

    // Learning rate
    label = 1; Hw = 0;
    record(100); record(-3);
    exp_a[0] = 100; exp_a[1] = -3;
    exp_b[0] = 25;  exp_b[1] = -1;
    run_pass("lr", 2, -1, 0);

    // Overfill then backpressure on the 2nd delta
    label = 1; Hw = 0;
    record(8); record(-8); record(12); record(20); record(30); record(40);
    chk("full_count", int'(cnt_a), 4);
    chk("full_flag", int'(full_a), 1);
    chk("full_drop", int'(drop_a), 1);
    exp_a[0] = 8; exp_a[1] = -8; exp_a[2] = 12; exp_a[3] = 20;
    exp_b[0] = 2; exp_b[1] = -2; exp_b[2] = 3;  exp_b[3] = 5;
    run_pass("bp", 4, 1, 3);
    chk("bp_drop_sticky", int'(drop_a), 1);

    // Clear mid-stream, with Record_X in the same cycle
    label = 1; Hw = 0;
    record(1); record(2); record(3);
    Up_W = 1'b1;
    tick();
    Up_W = 1'b0;
    dw_ready = 1'b1;
    tick();
    chk("clr_first", int'(d_a), 1);
    tick();
    chk("clr_second", int'(d_a), 2);
    dw_ready = 1'b0;
    Clear = 1'b1;
    Record_X = 1'b1;
    x_in = 8'sd9;
    tick();
    Clear = 1'b0;
    Record_X = 1'b0;
    chk("clr_valid", int'(v_a), 0);
    chk("clr_busy", int'(busy_a), 0);
    chk("clr_count", int'(cnt_a), 0);
    chk("clr_empty", int'(empty_a), 1);
    chk("clr_drop", int'(drop_a), 0);

    // Async reset mid-stream
    record(10); record(20); record(30);
    Up_W = 1'b1;
    tick();
    Up_W = 1'b0;
    dw_ready = 1'b0;
    tick();
    chk("ar_valid_pre", int'(v_a), 1);
    Record_X = 1'b1;
    x_in = 8'sd4;
    tick();
    Record_X = 1'b0;
    chk("ar_drop_in_pass", int'(drop_a), 1);
    chk("ar_count_in_pass", int'(cnt_a), 2);
    #2 RST = 1'b1;
    #1;
    chk("ar_valid", int'(v_a), 0);
    chk("ar_delta", int'(d_a), 0);
    chk("ar_busy", int'(busy_a), 0);
    chk("ar_count", int'(cnt_a), 0);
    chk("ar_empty", int'(empty_a), 1);
    chk("ar_drop", int'(drop_a), 0);
    chk("ar_last", int'(l_a), 0);
    dw_ready = 1'b1;
    tick();
    chk("ar_done_held", int'(done_a), 0);
    RST = 1'b0;
    tick();
    chk("ar_done_after", int'(done_a), 0);
    chk("ar_valid_after", int'(v_a), 0);
    chk("ar_busy_after", int'(busy_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
